message_unpad: RTL

Receive-side inverse of message_build for the SHA-2 engine. Consumes 512-bit SHA-2-padded blocks and strips the padding. Emits only the original message bits as 512-bit beats, plus a per-message status (recovered bit length, padding error). Used as the checker/loopback path for the builder, and as the front end for any consumer needing the raw message back.

---
 rtl/message_unpad.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/message_unpad.sv
// SHA-2 padding stripper: takes 512-bit padded blocks, emits the raw message
// bits as 512-bit beats plus a per-message status (bit length, padding error).
module message_unpad #(
    parameter int BLOCK_W = 512,
    parameter int LEN_W   = 64,
    parameter int CNT_W   = 55
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic               data_in_last,
    input  logic               data_in_valid,
    output logic               data_in_ready,
    output logic [BLOCK_W-1:0] data_out,
    output logic               data_out_last,
    output logic               data_out_valid,
    input  logic               data_out_ready,
    output logic [LEN_W-1:0]   msg_size,
    output logic               msg_err,
    output logic               msg_valid,
    input  logic               msg_ready
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam int         SHIFT    = $clog2(BLOCK_W);

    logic [1:0]         state_reg;
    logic [BLOCK_W-1:0] buf_reg;
    logic [BLOCK_W-1:0] flush_reg;
    logic [BLOCK_W-1:0] out_data_reg;
    logic               out_last_reg;
    logic               out_valid_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [LEN_W-1:0]   size_reg;
    logic               err_reg;
    logic               msg_valid_reg;
    logic               run_reg;

    logic [LEN_W-1:0]   len;
    logic [9:0]         r_ext;
    logic               held;
    logic               out_free;
    logic               in_ready;
    logic               in_fire;
    logic               split;
    logic               cnt_sat;
    logic [BLOCK_W-1:0] keep_mask;
    logic [BLOCK_W-1:0] marker_mask;
    logic [BLOCK_W-1:0] below_mask;
    logic [BLOCK_W-1:0] field_mask;
    logic [LEN_W:0]     blocks_exp;
    logic [LEN_W:0]     blocks_got;
    logic               pad_bad;
    logic               cnt_bad;
    logic [BLOCK_W-1:0] fin_data;
    logic               fin_last;
    logic               fin_flush;

    assign len      = data_in[LEN_W-1:0];
    assign r_ext    = {1'b0, len[SHIFT-1:0]};
    assign held     = (state_reg == ST_HOLD);
    assign out_free = !out_valid_reg || data_out_ready;
    assign split    = r_ext >= 10'(BLOCK_W - LEN_W);
    assign cnt_sat  = &cnt_reg;

    // Per-bit masks relative to the message end r: kept message bits, the
    // marker bit, and everything below the marker.
    for (genvar gi = 0; gi < BLOCK_W; gi++) begin : g_mask
        assign keep_mask[gi]   = (10'(gi) + r_ext) >= 10'(BLOCK_W);
        assign marker_mask[gi] = (10'(gi) + r_ext) == 10'(BLOCK_W - 1);
        assign below_mask[gi]  = (10'(gi) + r_ext) <  10'(BLOCK_W - 1);
        assign field_mask[gi]  = (gi >= LEN_W);
    end

    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            ST_EMPTY: in_ready = run_reg && !msg_valid_reg && out_free;
            ST_HOLD:  in_ready = out_free;
            default:  in_ready = 1'b0;
        endcase
    end
    assign in_fire = data_in_valid && in_ready;

    // When the message ends in the block before the length block, the marker
    // and the zero run live in the held buffer and spill into the final block.
    always_comb begin
        pad_bad = 1'b0;
        if (!split) begin
            pad_bad = !(|(data_in & marker_mask)) || (|(data_in & below_mask & field_mask));
        end else begin
            pad_bad = !held || !(|(buf_reg & marker_mask)) || (|(buf_reg & below_mask))
                      || (|(data_in & field_mask));
        end
    end

    assign blocks_exp = ({1'b0, len} + (LEN_W+1)'(BLOCK_W + LEN_W)) >> SHIFT;
    assign blocks_got = (LEN_W+1)'(held ? cnt_reg : '0) + (LEN_W+1)'(1);
    assign cnt_bad    = (blocks_got != blocks_exp) || (held && cnt_sat);

    always_comb begin
        fin_data  = '0;
        fin_last  = 1'b1;
        fin_flush = 1'b0;
        if (len == '0) begin
            fin_data = '0;
        end else if (r_ext == '0) begin
            fin_data = held ? buf_reg : '0;
        end else if (!split) begin
            if (held) begin
                fin_data  = buf_reg;
                fin_last  = 1'b0;
                fin_flush = 1'b1;
            end else begin
                fin_data = data_in & keep_mask;
            end
        end else begin
            fin_data = held ? (buf_reg & keep_mask) : '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg     <= ST_EMPTY;
            buf_reg       <= '0;
            flush_reg     <= '0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            cnt_reg       <= '0;
            size_reg      <= '0;
            err_reg       <= 1'b0;
            msg_valid_reg <= 1'b0;
            run_reg       <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (msg_valid_reg && msg_ready) msg_valid_reg <= 1'b0;
            if (out_valid_reg && data_out_ready) out_valid_reg <= 1'b0;

            if (state_reg == ST_FLUSH) begin
                if (out_free) begin
                    out_data_reg  <= flush_reg;
                    out_last_reg  <= 1'b1;
                    out_valid_reg <= 1'b1;
                    msg_valid_reg <= 1'b1;
                    state_reg     <= ST_EMPTY;
                end
            end else if (in_fire) begin
                if (!data_in_last) begin
                    if (held) begin
                        out_data_reg  <= buf_reg;
                        out_last_reg  <= 1'b0;
                        out_valid_reg <= 1'b1;
                        if (!cnt_sat) cnt_reg <= cnt_reg + CNT_W'(1);
                    end else begin
                        cnt_reg <= CNT_W'(1);
                    end
                    buf_reg   <= data_in;
                    state_reg <= ST_HOLD;
                end else begin
                    size_reg      <= len;
                    err_reg       <= pad_bad || cnt_bad;
                    out_data_reg  <= fin_data;
                    out_last_reg  <= fin_last;
                    out_valid_reg <= 1'b1;
                    if (fin_flush) begin
                        flush_reg <= data_in & keep_mask;
                        state_reg <= ST_FLUSH;
                    end else begin
                        msg_valid_reg <= 1'b1;
                        state_reg     <= ST_EMPTY;
                    end
                end
            end
        end
    end

    assign data_in_ready  = in_ready;
    assign data_out       = out_data_reg;
    assign data_out_last  = out_last_reg;
    assign data_out_valid = out_valid_reg;
    assign msg_size       = size_reg;
    assign msg_err        = err_reg;
    assign msg_valid      = msg_valid_reg;

endmodule
